nway_gate_sweeper: RTL and testbench

- Parametrised N-input logic gate with selectable function (AND/OR/NAND/NOR/XOR/XNOR) and a registered output.
- Built-in sweep sequencer walks all 2^N_IN input patterns with a programmable dwell per pattern, and counts patterns that produce 1 (truth-table popcount).
- Replaces fixed 4-input gate labs plus their hand-timed toggling stimulus; used standalone on the board or as a self-checking gate unit.

---
 rtl/nway_gate_sweeper.sv | 145 ++++++++++++++
 tb/tb_nway_gate_sweeper.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nway_gate_sweeper.sv
// rtl/nway_gate_sweeper.sv - N-input selectable gate with registered output and truth-table sweep sequencer
`timescale 1ns/1ps

module nway_gate_sweeper #(
    parameter int N_IN  = 4,
    parameter int DWELL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      mode,
    input  logic            ext_en,
    input  logic [N_IN-1:0] ext_in,
    output logic [N_IN-1:0] pattern,
    output logic            gate_out,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   ones_count
);

    // A dwell of one cycle still gets a 1-bit counter so the compare stays legal.
    localparam int              DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
    localparam logic [N_IN-1:0] ALL_ONES   = '1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t          r_state;
    logic [N_IN-1:0] r_pattern;
    logic            r_gate;
    logic            r_busy;
    logic            r_done;
    logic [N_IN:0]   r_ones;
    logic [DW-1:0]   r_dwell;
    logic [2:0]      r_mode_q;

    state_t          w_state_nxt;
    logic [N_IN-1:0] w_pattern_nxt;
    logic            w_gate_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic [N_IN:0]   w_ones_nxt;
    logic [DW-1:0]   w_dwell_nxt;
    logic [2:0]      w_mode_q_nxt;
    logic [2:0]      w_mode_eff;
    logic            w_dwell_end;
    logic            w_pattern_last;

    // Reduction of the pattern selected by the mode code; codes 11x give constant 0.
    function automatic logic gate_fn(input logic [N_IN-1:0] p, input logic [2:0] m);
        case (m)
            3'b000:  return &p;
            3'b001:  return |p;
            3'b010:  return ~&p;
            3'b011:  return ~|p;
            3'b100:  return ^p;
            3'b101:  return ~^p;
            default: return 1'b0;
        endcase
    endfunction

    // Next-state and next-value logic; while sweeping, the latched mode drives the gate.
    always_comb begin
        w_state_nxt    = r_state;
        w_pattern_nxt  = r_pattern;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_ones_nxt     = r_ones;
        w_dwell_nxt    = r_dwell;
        w_mode_q_nxt   = r_mode_q;
        w_mode_eff     = (r_state == S_IDLE) ? mode : r_mode_q;
        w_gate_nxt     = gate_fn(r_pattern, w_mode_eff);
        w_dwell_end    = (r_dwell == DWELL_LAST);
        w_pattern_last = (r_pattern == ALL_ONES);

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mode_q_nxt  = mode;
                    w_pattern_nxt = '0;
                    w_dwell_nxt   = '0;
                    w_ones_nxt    = '0;
                    w_done_nxt    = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = S_SWEEP;
                end else if (ext_en) begin
                    w_pattern_nxt = ext_in;
                end
            end
            S_SWEEP: begin
                if (w_dwell_end) begin
                    if (gate_fn(r_pattern, r_mode_q)) begin
                        w_ones_nxt = r_ones + (N_IN+1)'(1);
                    end
                    if (!w_pattern_last) begin
                        w_pattern_nxt = r_pattern + N_IN'(1);
                        w_dwell_nxt   = '0;
                    end else begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + DW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any sweep in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pattern <= '0;
            r_gate    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ones    <= '0;
            r_dwell   <= '0;
            r_mode_q  <= 3'b000;
        end else begin
            r_state   <= w_state_nxt;
            r_pattern <= w_pattern_nxt;
            r_gate    <= w_gate_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_ones    <= w_ones_nxt;
            r_dwell   <= w_dwell_nxt;
            r_mode_q  <= w_mode_q_nxt;
        end
    end

    assign pattern    = r_pattern;
    assign gate_out   = r_gate;
    assign busy       = r_busy;
    assign done       = r_done;
    assign ones_count = r_ones;

endmodule

// File: tb/tb_nway_gate_sweeper.sv
// tb/tb_nway_gate_sweeper.sv - randomized self-checking bench for nway_gate_sweeper
`timescale 1ns/1ps

module tb_nway_gate_sweeper;

    logic clk = 1'b0;
    logic rst;

    logic       a_start, a_ext_en, a_gate, a_busy, a_done;
    logic [2:0] a_mode;
    logic [3:0] a_ext_in, a_pattern;
    logic [4:0] a_ones;

    logic       b_start, b_ext_en, b_gate, b_busy, b_done;
    logic [2:0] b_mode;
    logic [3:0] b_ext_in, b_pattern;
    logic [4:0] b_ones;

    logic       c_start, c_ext_en, c_gate, c_busy, c_done;
    logic [2:0] c_mode;
    logic [7:0] c_ext_in, c_pattern;
    logic [8:0] c_ones;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nway_gate_sweeper #(.N_IN(4), .DWELL(1)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .ext_en(a_ext_en), .ext_in(a_ext_in),
        .pattern(a_pattern), .gate_out(a_gate), .busy(a_busy), .done(a_done), .ones_count(a_ones)
    );

    nway_gate_sweeper #(.N_IN(4), .DWELL(50)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .ext_en(b_ext_en), .ext_in(b_ext_in),
        .pattern(b_pattern), .gate_out(b_gate), .busy(b_busy), .done(b_done), .ones_count(b_ones)
    );

    nway_gate_sweeper #(.N_IN(8), .DWELL(1)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .mode(c_mode), .ext_en(c_ext_en), .ext_in(c_ext_in),
        .pattern(c_pattern), .gate_out(c_gate), .busy(c_busy), .done(c_done), .ones_count(c_ones)
    );

    // Reference gate: decided from the pattern's value and its count of set bits.
    function automatic logic ref_f(input int p, input int m, input int n);
        int all_ones;
        int ones;
        all_ones = (1 << n) - 1;
        ones = 0;
        for (int i = 0; i < n; i++) ones += (p >> i) & 1;
        case (m)
            0:       return p == all_ones;
            1:       return p != 0;
            2:       return p != all_ones;
            3:       return p == 0;
            4:       return (ones % 2) == 1;
            5:       return (ones % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int ref_count(input int m, input int n);
        int s;
        s = 0;
        for (int p = 0; p < (1 << n); p++) s += int'(ref_f(p, m, n));
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({a_pattern, a_gate, a_busy, a_done, a_ones} !== 12'h0) begin
                n_fail++;
                $display("FAIL reset_outputs_a cyc%0d: got pat=%h gate=%b busy=%b done=%b ones=%0d, want all 0",
                         i, a_pattern, a_gate, a_busy, a_done, a_ones);
            end
            n_checks++;
            if ({b_pattern, b_gate, b_busy, b_done, b_ones, c_pattern, c_gate, c_busy, c_done, c_ones} !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs_bc cyc%0d: got b_pat=%h c_pat=%h c_ones=%0d b_done=%b c_done=%b, want all 0",
                         i, b_pattern, c_pattern, c_ones, b_done, c_done);
            end
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if ({a_gate, a_pattern, a_busy, a_done} !== {1'b1, 4'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release: got gate=%b pat=%h busy=%b done=%b, want gate=1 pat=0 busy=0 done=0",
                     a_gate, a_pattern, a_busy, a_done);
        end
    endtask

    // Full DWELL=1 sweep on u_a; ignored inputs are jittered while busy.
    task automatic run_sweep4(input int m, input int exp_ones);
        logic [6:0] got, exp;
        a_mode  = 3'(m);
        a_start = 1'b1;
        tick();
        n_checks++;
        if ({a_pattern, a_busy, a_done, a_ones} !== {4'h0, 1'b1, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL sweep_start m=%0d: got pat=%h busy=%b done=%b ones=%0d, want pat=0 busy=1 done=0 ones=0",
                     m, a_pattern, a_busy, a_done, a_ones);
        end
        for (int j = 0; j < 16; j++) begin
            if (j < 15) begin
                a_mode   = 3'($urandom_range(0, 7));
                a_start  = 1'($urandom_range(0, 1));
                a_ext_en = 1'($urandom_range(0, 1));
                a_ext_in = 4'($urandom);
            end else begin
                a_mode   = 3'(m);
                a_start  = 1'b0;
                a_ext_en = 1'b0;
            end
            tick();
            got = {a_pattern, a_busy, a_gate, a_done};
            exp = {4'((j + 1 < 16) ? j + 1 : 15), 1'(j + 1 < 16), ref_f(j, m, 4), 1'(j + 1 == 16)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL sweep_step m=%0d j=%0d: got {pat,busy,gate,done}=%b, want %b", m, j + 1, got, exp);
            end
        end
        n_checks++;
        if (a_ones !== 5'(exp_ones)) begin
            n_fail++;
            $display("FAIL sweep_count m=%0d: got ones=%0d, want %0d", m, a_ones, exp_ones);
        end
        tick();
        n_checks++;
        if ({a_done, a_busy, a_ones} !== {1'b1, 1'b0, 5'(exp_ones)}) begin
            n_fail++;
            $display("FAIL sweep_hold m=%0d: got done=%b busy=%b ones=%0d, want done=1 busy=0 ones=%0d",
                     m, a_done, a_busy, a_ones, exp_ones);
        end
    endtask

    task automatic test_sweeps();
        int tab[8] = '{1, 15, 15, 1, 8, 8, 0, 0};
        int m;
        for (int k = 0; k < 8; k++) run_sweep4(k, tab[k]);
        for (int k = 0; k < 3; k++) begin
            m = $urandom_range(0, 7);
            run_sweep4(m, ref_count(m, 4));
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses  = 0;
        a_mode  = 3'd4;
        a_start = 1'b1;
        tick();
        for (int j = 1; j <= 33; j++) begin
            tick();
            if (j <= 32 && a_done) pulses++;
            if (j == 16) begin
                n_checks++;
                if ({a_done, a_busy, a_ones} !== {1'b1, 1'b0, 5'd8}) begin
                    n_fail++;
                    $display("FAIL b2b_first_done: got done=%b busy=%b ones=%0d, want 1 0 8", a_done, a_busy, a_ones);
                end
            end
            if (j == 17) begin
                n_checks++;
                if ({a_done, a_busy, a_pattern, a_ones} !== {1'b0, 1'b1, 4'h0, 5'd0}) begin
                    n_fail++;
                    $display("FAIL b2b_restart: got done=%b busy=%b pat=%h ones=%0d, want 0 1 0 0",
                             a_done, a_busy, a_pattern, a_ones);
                end
            end
        end
        a_start = 1'b0;
        n_checks++;
        if ({a_done, a_ones} !== {1'b1, 5'd8}) begin
            n_fail++;
            $display("FAIL b2b_second_done: got done=%b ones=%0d, want 1 8", a_done, a_ones);
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL b2b_done_pulse: got %0d done-high cycles, want 1", pulses);
        end
        tick();
    endtask

    // DWELL=50 NOR sweep on u_b, with mode/start/ext_en disturbed mid-sweep.
    task automatic test_dwell50();
        logic [6:0] got, exp;
        int rises, prev_p, live_m;
        logic last_done;
        b_mode  = 3'd3;
        b_start = 1'b1;
        tick();
        b_start   = 1'b0;
        last_done = b_done;
        rises     = 0;
        live_m    = 3;
        n_checks++;
        if ({b_busy, b_pattern} !== {1'b1, 4'h0}) begin
            n_fail++;
            $display("FAIL dwell_start: got busy=%b pat=%h, want 1 0", b_busy, b_pattern);
        end
        for (int j = 1; j <= 803; j++) begin
            if (j == 300) begin
                b_mode   = 3'd0;
                live_m   = 0;
                b_start  = 1'b1;
                b_ext_en = 1'b1;
                b_ext_in = 4'($urandom);
            end
            if (j == 303) begin
                b_start  = 1'b0;
                b_ext_en = 1'b0;
            end
            prev_p = (j - 1 < 800) ? (j - 1) / 50 : 15;
            tick();
            if (b_done && !last_done) rises++;
            last_done = b_done;
            got = {b_pattern, b_busy, b_gate, b_done};
            exp = {4'((j < 800) ? j / 50 : 15), 1'(j < 800), ref_f(prev_p, (j <= 800) ? 3 : live_m, 4), 1'(j >= 800)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL dwell_step j=%0d: got {pat,busy,gate,done}=%b, want %b", j, got, exp);
            end
        end
        n_checks++;
        if (b_ones !== 5'd1) begin
            n_fail++;
            $display("FAIL dwell_count: got ones=%0d, want 1", b_ones);
        end
        n_checks++;
        if (rises !== 1) begin
            n_fail++;
            $display("FAIL dwell_done_rises: got %0d, want 1", rises);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        a_mode  = 3'd3;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        guard   = 0;
        while (a_pattern !== 4'h7 && guard < 20) begin
            tick();
            guard++;
        end
        n_checks++;
        if (a_pattern !== 4'h7) begin
            n_fail++;
            $display("FAIL reset_mid_reach: got pat=%h after %0d cycles, want 7", a_pattern, guard);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({a_pattern, a_busy, a_done, a_ones} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got pat=%h busy=%b done=%b ones=%0d, want all 0",
                     a_pattern, a_busy, a_done, a_ones);
        end
        run_sweep4(3, 1);
    endtask

    // N_IN=8 external loading with random mode, then one full 256-pattern sweep.
    task automatic test_ext8();
        logic [7:0] mp, pre, in;
        logic en;
        int md, cyc;
        c_mode   = 3'd4;
        c_ext_en = 1'b1;
        c_ext_in = 8'hA5;
        tick();
        n_checks++;
        if (c_pattern !== 8'hA5) begin
            n_fail++;
            $display("FAIL ext_load: got pat=%h, want a5", c_pattern);
        end
        tick();
        n_checks++;
        if (c_gate !== 1'b0) begin
            n_fail++;
            $display("FAIL ext_xor_a5: got gate=%b, want 0", c_gate);
        end
        c_ext_in = 8'hA4;
        tick();
        n_checks++;
        if ({c_pattern, c_gate} !== {8'hA4, 1'b0}) begin
            n_fail++;
            $display("FAIL ext_a4_edge1: got pat=%h gate=%b, want a4 0", c_pattern, c_gate);
        end
        tick();
        n_checks++;
        if (c_gate !== 1'b1) begin
            n_fail++;
            $display("FAIL ext_xor_a4: got gate=%b, want 1", c_gate);
        end
        mp = 8'hA4;
        for (int i = 0; i < 40; i++) begin
            en  = 1'($urandom_range(0, 1));
            in  = 8'($urandom);
            md  = $urandom_range(0, 7);
            c_ext_en = en;
            c_ext_in = in;
            c_mode   = 3'(md);
            pre = mp;
            tick();
            if (en) mp = in;
            n_checks++;
            if ({c_pattern, c_gate} !== {mp, ref_f(int'(pre), md, 8)}) begin
                n_fail++;
                $display("FAIL ext_random i=%0d: got pat=%h gate=%b, want pat=%h gate=%b",
                         i, c_pattern, c_gate, mp, ref_f(int'(pre), md, 8));
            end
        end
        c_ext_en = 1'b0;
        md       = $urandom_range(0, 7);
        c_mode   = 3'(md);
        c_start  = 1'b1;
        tick();
        c_start = 1'b0;
        cyc     = 0;
        while (c_busy && cyc < 400) begin
            cyc++;
            tick();
        end
        n_checks++;
        if (cyc !== 256) begin
            n_fail++;
            $display("FAIL sweep8_busy_len: got %0d busy cycles, want 256", cyc);
        end
        n_checks++;
        if ({c_done, c_ones} !== {1'b1, 9'(ref_count(md, 8))}) begin
            n_fail++;
            $display("FAIL sweep8_count m=%0d: got done=%b ones=%0d, want done=1 ones=%0d",
                     md, c_done, c_ones, ref_count(md, 8));
        end
    endtask

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_ext_en = 1'b0; a_mode = 3'd3; a_ext_in = 4'h0;
        b_start = 1'b0; b_ext_en = 1'b0; b_mode = 3'd3; b_ext_in = 4'h0;
        c_start = 1'b0; c_ext_en = 1'b0; c_mode = 3'd0; c_ext_in = 8'h0;
        test_reset();
        test_sweeps();
        test_back_to_back();
        test_dwell50();
        test_reset_mid();
        test_ext8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, want finish");
        $fatal(1);
    end

endmodule
